// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the file-register port arbiter: memory-map SFR
// addresses, arbiter FSM states and the core-SFR address decoder.
package regfile_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DBG_RD_HOLD = 2'd1,
    DBG_RD_WAIT = 2'd2
  } arb_state_t;

  localparam logic [8:0] SFR_TMR0   = 9'h001;
  localparam logic [8:0] SFR_PCL    = 9'h002;
  localparam logic [8:0] SFR_STATUS = 9'h003;
  localparam logic [8:0] SFR_FSR    = 9'h004;
  localparam logic [8:0] SFR_PCLATH = 9'h00A;
  localparam logic [8:0] SFR_INTCON = 9'h00B;
  localparam logic [8:0] SFR_PIR1   = 9'h00C;
  localparam logic [8:0] SFR_OPTION = 9'h081;
  localparam logic [8:0] SFR_PIE1   = 9'h08C;
  localparam logic [8:0] SFR_PCON   = 9'h08E;

  // PCL/STATUS/FSR/PCLATH/INTCON mirror in every bank; offset 0x01 is TMR0 in
  // banks 0/2 and OPTION in banks 1/3, so it is protected everywhere.
  function automatic logic is_core_sfr(input logic [8:0] addr);
    logic [6:0] ofs;
    logic [1:0] bank;
    ofs  = addr[6:0];
    bank = addr[8:7];
    is_core_sfr = (ofs == SFR_PCL[6:0])    || (ofs == SFR_STATUS[6:0]) ||
                  (ofs == SFR_FSR[6:0])    || (ofs == SFR_PCLATH[6:0]) ||
                  (ofs == SFR_INTCON[6:0]) || (ofs == SFR_TMR0[6:0])   ||
                  (ofs == SFR_OPTION[6:0]) ||
                  ((ofs == SFR_PIR1[6:0]) && (bank == 2'd0)) ||
                  ((ofs == SFR_PIE1[6:0]) && (bank == 2'd1)) ||
                  ((ofs == SFR_PCON[6:0]) && (bank == 2'd1));
  endfunction

endpackage

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the single file-register port between the CPU core and a debug
// requester. Optional REGFILE_ARB_SFR_PROTECT_EN suppresses debug SFR writes.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] core_addr,
  input  logic       core_rd_en,
  input  logic       core_wr_en,
  input  logic [7:0] core_wdata,
  output logic       core_stall,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [8:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_gnt,
  output logic       dbg_rvalid,
  output logic [7:0] dbg_rdata,
  output logic       dbg_wr_blocked,
  output logic [8:0] rf_addr,
  output logic       rf_rd_en,
  output logic       rf_wr_en,
  output logic [7:0] rf_wdata,
  input  logic [7:0] rf_rdata
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  arb_state_t state;
  logic [7:0] wait_cnt;
  logic       core_rd_last;
  logic [8:0] dbg_addr_q;
  logic [7:0] dbg_rdata_q;
  logic       force_slot;
  logic       slot_free;
  logic       issue;
  logic       wr_blocked;

  // A debug slot never starts right after a core read, since the port must
  // keep the core's address for the second read cycle.
  always_comb begin
    force_slot = (state == IDLE) && dbg_req && (wait_cnt == MAX_WAIT_C) && !core_rd_last;
    slot_free  = (!core_rd_en && !core_wr_en && !core_rd_last) || force_slot;
    issue      = (state == IDLE) && dbg_req && slot_free;
`ifdef REGFILE_ARB_SFR_PROTECT_EN
    wr_blocked = issue && dbg_we && is_core_sfr(dbg_addr);
`else
    wr_blocked = 1'b0;
`endif
  end

  always_comb begin
    rf_addr  = core_addr;
    rf_rd_en = core_rd_en;
    rf_wr_en = core_wr_en;
    rf_wdata = core_wdata;
    if (issue) begin
      rf_addr  = dbg_addr;
      rf_rd_en = !dbg_we;
      rf_wr_en = dbg_we && !wr_blocked;
      rf_wdata = dbg_we ? dbg_wdata : 8'h00;
    end else if (state == DBG_RD_HOLD) begin
      rf_addr  = dbg_addr_q;
      rf_rd_en = 1'b0;
      rf_wr_en = 1'b0;
      rf_wdata = 8'h00;
    end
  end

  // Read data is forwarded in the return cycle and held afterwards.
  always_comb begin
    core_stall     = (issue && force_slot) || (state == DBG_RD_HOLD);
    dbg_gnt        = issue;
    dbg_wr_blocked = wr_blocked;
    dbg_rvalid     = (state == DBG_RD_WAIT);
    dbg_rdata      = (state == DBG_RD_WAIT) ? rf_rdata : dbg_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      core_rd_last <= 1'b0;
      dbg_addr_q   <= 9'd0;
      dbg_rdata_q  <= 8'd0;
    end else begin
      core_rd_last <= core_rd_en && !core_stall;
      if (!dbg_req || issue) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != MAX_WAIT_C) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (issue && !dbg_we) begin
            state      <= DBG_RD_HOLD;
            dbg_addr_q <= dbg_addr;
          end
        end
        DBG_RD_HOLD: state <= DBG_RD_WAIT;
        DBG_RD_WAIT: begin
          dbg_rdata_q <= rf_rdata;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
